// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Up-counter measuring how long an imem response has been outstanding.
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= count + CW'(1);
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding imem request, stall/redirect handling.
//  state   | meaning
//  FETCH   | request driven, waiting for grant
//  WAIT    | granted, waiting for response
//  HOLD    | response buffered while load-use stall is active
//  DISCARD | wrong-path response outstanding, to be dropped
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NOP_INSTR      = FETCH_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        branch_taken_mem,
  input  logic        load_use_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        ifid_write,
  output logic        pc_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        timeout_err
);

  fetch_state_t state;
  logic [31:0]  hold_buf;
  logic         err_q;
  logic         waiting, expired, cnt_en, timed_out;

  assign waiting   = (state == WAIT) || (state == DISCARD);
  assign cnt_en    = waiting && !imem_rvalid && !expired;
  assign timed_out = waiting && !imem_rvalid && expired;

  fetch_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .clr     (!cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      hold_buf <= NOP_INSTR;
      err_q    <= 1'b0;
    end else begin
      if (timed_out) err_q <= 1'b1;
      unique case (state)
        FETCH: begin
          if (imem_gnt) state <= branch_taken_mem ? DISCARD : WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!branch_taken_mem && load_use_stall) begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
            end else begin
              state <= FETCH;
            end
          end else if (expired) begin
            state <= FETCH;
          end else if (branch_taken_mem) begin
            state <= DISCARD;
          end
        end
        HOLD: begin
          if (branch_taken_mem) begin
            hold_buf <= NOP_INSTR;
            state    <= FETCH;
          end else if (!load_use_stall) begin
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (imem_rvalid || expired) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs are combinational so a response reaches IF/ID in the cycle it arrives.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_out   = NOP_INSTR;
    ifid_write  = 1'b0;
    pc_write    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    timeout_err = 1'b0;
    if (!rst) begin
      timeout_err = err_q;
      imem_req    = (state == FETCH);
      imem_addr   = imem_req ? pc_in : '0;
      if (state == HOLD) instr_out = hold_buf;
      if (branch_taken_mem) begin
        pc_write    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use_stall) begin
        idex_flush = 1'b1;
      end else if (state == WAIT && imem_rvalid) begin
        instr_out  = imem_rdata;
        ifid_write = 1'b1;
        pc_write   = 1'b1;
      end else if (state == HOLD) begin
        ifid_write = 1'b1;
        pc_write   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a short timeout.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        branch_taken_mem, load_use_stall;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, instr_out;
  logic        ifid_write, pc_write, ifid_flush, idex_flush, exmem_flush, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_controller #(.TIMEOUT_CYCLES(8), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_in            (pc_in),
    .branch_taken_mem (branch_taken_mem),
    .load_use_stall   (load_use_stall),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instr_out        (instr_out),
    .ifid_write       (ifid_write),
    .pc_write         (pc_write),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed afterwards, checks follow a settle delay.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Checks the packed control outputs {req,pc_write,ifid_write,ifid_flush,idex_flush,exmem_flush,err}.
  task automatic ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, imem_req, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, timeout_err},
        {25'd0, exp});
  endtask

  // One zero-wait fetch starting in FETCH: grant, then response next cycle.
  task automatic fetch_ok(input logic [31:0] pc, input logic [31:0] data, input logic err);
    pc_in = pc; imem_gnt = 1'b1; imem_rvalid = 1'b0; settle();
    chk("fetch_addr", imem_addr, pc);
    ctl("fetch_req", {1'b1, 5'b00000, err});
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data; settle();
    ctl("fetch_resp_ctl", {1'b0, 1'b1, 1'b1, 3'b000, err});
    chk("fetch_resp_instr", instr_out, data);
    tick();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'h0; branch_taken_mem = 1'b0; load_use_stall = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick(); tick(); settle();
    ctl("reset_ctl", 7'b0);
    chk("reset_instr", instr_out, NOP);
    chk("reset_addr", imem_addr, 32'h0);

    // Zero-wait fetches, addresses 0,4,8
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    fetch_ok(32'h0, 32'h0050_0093, 1'b0);
    fetch_ok(32'h4, 32'h0060_0113, 1'b0);

    // Load-use stall on the response cycle, held two cycles
    pc_in = 32'h8; imem_gnt = 1'b1; settle();
    chk("stall_addr", imem_addr, 32'h8);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113; load_use_stall = 1'b1; settle();
    ctl("stall_c1", 7'b0000100);
    chk("stall_c1_instr", instr_out, NOP);
    tick();
    imem_rvalid = 1'b0; settle();
    ctl("stall_c2", 7'b0000100);
    chk("stall_c2_instr", instr_out, 32'h00A0_0113);
    tick();
    load_use_stall = 1'b0; settle();
    ctl("stall_release", 7'b0110000);
    chk("stall_release_instr", instr_out, 32'h00A0_0113);
    tick(); settle();
    ctl("stall_back_fetch", 7'b1000000);

    // Redirect while waiting; wrong-path response three cycles later
    pc_in = 32'hC; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; branch_taken_mem = 1'b1; settle();
    ctl("redir_wait", 7'b0101110);
    tick();
    branch_taken_mem = 1'b0; pc_in = 32'h100; settle();
    ctl("redir_discard", 7'b0);
    tick(); tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
    ctl("redir_drop", 7'b0);
    chk("redir_drop_instr", instr_out, NOP);
    tick();
    imem_rvalid = 1'b0; settle();
    ctl("redir_refetch", 7'b1000000);
    chk("redir_refetch_addr", imem_addr, 32'h100);

    // Redirect coincident with grant
    imem_gnt = 1'b1; branch_taken_mem = 1'b1; settle();
    ctl("redir_gnt", 7'b1101110);
    tick();
    imem_gnt = 1'b0; branch_taken_mem = 1'b0; settle();
    ctl("redir_gnt_discard", 7'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; settle();
    ctl("redir_gnt_drop", 7'b0);
    tick();
    imem_rvalid = 1'b0; settle();
    ctl("redir_gnt_fetch", 7'b1000000);

    // Timeout: eight WAIT cycles without a response
    pc_in = 32'h104; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      ctl($sformatf("tmo_wait%0d", i), 7'b0);
      tick();
    end
    settle();
    ctl("tmo_retry", 7'b1000001);
    chk("tmo_retry_addr", imem_addr, 32'h104);
    fetch_ok(32'h104, 32'h0000_0073, 1'b1);
    settle();
    ctl("tmo_sticky", 7'b1000001);

    // Reset asserted while holding a buffered instruction
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001; load_use_stall = 1'b1; tick();
    imem_rvalid = 1'b0; settle();
    chk("hold_instr", instr_out, 32'hCAFE_0001);
    rst = 1'b1; settle();
    ctl("rst_hold_ctl", 7'b0);
    chk("rst_hold_instr", instr_out, NOP);
    tick();
    rst = 1'b0; load_use_stall = 1'b0; settle();
    ctl("rst_to_fetch", 7'b1000000);
    chk("rst_to_fetch_instr", instr_out, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch for the 5-stage pipelined RISC-V core.
- Sits between the program counter and a variable-latency instruction memory, and generates the PC write enable.
- Generates IF/ID write and pipeline flushes for load-use stalls and MEM-stage branch redirects.
- Allows one outstanding imem request; discards wrong-path responses after a redirect.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles waiting for imem_rvalid before abort and retry.
- NOP_INSTR, 32'h0000_0013, instruction presented on instr_out when nothing is valid.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- pc_in  in  32  current PC from program counter
- branch_taken_mem  in  1  one-cycle redirect pulse from MEM stage; PC target is applied by the program counter
- load_use_stall  in  1  hazard unit stall request, level
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals pc_in while imem_req=1
- imem_gnt  in  1  imem accepted request this cycle
- imem_rvalid  in  1  response valid, never earlier than the cycle after imem_gnt
- imem_rdata  in  32  response instruction
- instr_out  out  32  instruction for IF/ID
- ifid_write  out  1  IF/ID load enable
- pc_write  out  1  program counter write enable
- ifid_flush  out  1  clear IF/ID
- idex_flush  out  1  clear ID/EX (insert bubble)
- exmem_flush  out  1  clear EX/MEM
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst

Behaviour:
- States: FETCH, WAIT, HOLD, DISCARD. Reset state is FETCH.
- While rst=1 all outputs are 0; instr_out=NOP_INSTR, hold buffer=NOP_INSTR, timeout counter=0, timeout_err=0.
- FETCH:
  - imem_req=1.
  - imem_gnt → WAIT.
- WAIT:
  - imem_rvalid & !load_use_stall → instr_out=imem_rdata (combinational), ifid_write=1, pc_write=1, → FETCH. Fetch latency is gnt-to-rvalid plus 0 cycles.
  - imem_rvalid & load_use_stall → capture imem_rdata into hold buffer, → HOLD.
- HOLD:
  - instr_out = hold buffer.
  - !load_use_stall → ifid_write=1, pc_write=1, → FETCH.
- DISCARD:
  - imem_rvalid → drop data, → FETCH.
  - No ifid_write or pc_write.
- load_use_stall=1 in any state without redirect:
  - pc_write=0, ifid_write=0, idex_flush=1.
  - A FETCH request still issues; a grant moves to WAIT.
- Redirect (branch_taken_mem=1) has highest priority and overrides the stall.
  - Same cycle: pc_write=1, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - FETCH with imem_gnt the same cycle → DISCARD; FETCH without grant → FETCH.
  - WAIT with imem_rvalid the same cycle → FETCH (response dropped); WAIT without rvalid → DISCARD.
  - HOLD → FETCH, hold buffer dropped.
  - DISCARD → DISCARD, or FETCH if imem_rvalid the same cycle.
- Timeout:
  - Counter increments each cycle in WAIT or DISCARD without rvalid, and resets on leaving those states.
  - At count == TIMEOUT_CYCLES-1 without rvalid: next state FETCH, timeout_err←1.
  - A late response after a timeout is ignored only if it arrives while in FETCH; imem is required not to issue one.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Asserting rst mid-transaction returns to FETCH next cycle; any in-flight response is ignored while rst=1.
- imem_rvalid in FETCH or HOLD is a protocol error and is ignored.
- Flush outputs are single-cycle, combinational from inputs and state.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {FETCH, WAIT, HOLD, DISCARD}.
  - NOP constant.
  - localparam function for counter width.
- Sub-module fetch_timeout_counter (clk, rst, en, clr, expired), parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset then zero-wait imem (gnt in FETCH, rvalid next cycle, rdata=32'h00500093) → pc_write and ifid_write pulse together with instr_out=32'h00500093; imem_addr steps 0,4,8.
- Load-use stall asserted the cycle rvalid arrives, held 2 cycles → state HOLD, idex_flush=1 for 2 cycles, pc_write=0; on release ifid_write=1 with buffered instr.
- branch_taken_mem in WAIT, rvalid 3 cycles later → flushes all high for 1 cycle, pc_write=1, late response dropped (ifid_write stays 0), next req at new pc_in.
- branch_taken_mem same cycle as imem_gnt in FETCH → DISCARD entered; subsequent rvalid dropped.
- Withhold rvalid, TIMEOUT_CYCLES=8 → after 8 WAIT cycles, imem_req reasserts and timeout_err=1, stays 1 until rst.
- rst asserted in HOLD → next cycle all outputs 0, then FETCH with imem_req=1.
